// File: rtl/filter_serializer.sv
// Parallel-to-serial transmitter: captures up to DEPTH filter words in one load
// and sends them highest index first over a valid/ready handshake, then pulses done.
module filter_serializer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 24,
  parameter int CW    = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [CW-1:0]          p,
  input  logic [WIDTH*DEPTH-1:0] d_flat,
  output logic [WIDTH-1:0]       q,
  output logic                   q_valid,
  input  logic                   q_ready,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_r, state_n;
  logic [CW-1:0]    index_r, index_n;
  logic [CW-1:0]    p_lat_s, p_first_s, index_dec_s;
  logic [WIDTH-1:0] hold_r [DEPTH];
  logic [WIDTH-1:0] d_words_s [DEPTH];
  logic [WIDTH-1:0] q_r, q_n;
  logic             q_valid_r, busy_r, done_r;
  logic             hold_en_s;

  for (genvar i = 0; i < DEPTH; i++) begin : g_unpack
    assign d_words_s[i] = d_flat[i*WIDTH +: WIDTH];
  end

  assign p_lat_s     = (p > CW'(DEPTH)) ? CW'(DEPTH) : p;
  assign p_first_s   = p_lat_s - CW'(1);
  assign index_dec_s = index_r - CW'(1);

  // Next-state, next-index and next-word selection.
  always_comb begin
    state_n   = state_r;
    index_n   = index_r;
    q_n       = q_r;
    hold_en_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (load) begin
          hold_en_s = 1'b1;
          if (p_lat_s == CW'(0)) begin
            state_n = DONE;
          end else begin
            state_n = SHIFT;
            index_n = p_first_s;
            q_n     = d_words_s[p_first_s];
          end
        end else begin
          state_n = IDLE;
        end
      end
      SHIFT: begin
        if (q_ready) begin
          if (index_r == CW'(0)) begin
            state_n = DONE;
          end else begin
            index_n = index_dec_s;
            q_n     = hold_r[index_dec_s];
          end
        end else begin
          state_n = SHIFT;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, datapath and output registers; outputs are precomputed from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      index_r   <= '0;
      q_r       <= '0;
      q_valid_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        hold_r[i] <= '0;
      end
    end else begin
      state_r   <= state_n;
      index_r   <= index_n;
      q_r       <= q_n;
      q_valid_r <= (state_n == SHIFT);
      busy_r    <= (state_n != IDLE);
      done_r    <= (state_n == DONE);
      if (hold_en_s) begin
        hold_r <= d_words_s;
      end
    end
  end

  assign q       = q_r;
  assign q_valid = q_valid_r;
  assign busy    = busy_r;
  assign done    = done_r;

endmodule

// File: doc/filter_serializer.md
Name: filter_serializer

Overview:
- Parallel-to-serial transmitter: the counterpart of the PE output collector that gathers one filter result per clock into 24 parallel words.
- Captures up to 24 parallel 16-bit filter results in one load, then drives them out one word per transfer on a single 16-bit line with a valid/ready handshake.
- Pulses done after the last word.
- Word order is highest active index first (d[p-1] ... d[0]), so a serial collector downstream rebuilds the same word-to-index arrangement.

Parameters:
- WIDTH, 16, bits per filter word
- DEPTH, 24, maximum number of words (maximum p)
- CW, 5, width of p and of the internal index counter

Ports:
- clk  input  1  single clock, all state on posedge
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk
- load  input  1  start request; sampled only in IDLE
- p  input  CW  number of words to send, sampled with load
- d_flat  input  WIDTH*DEPTH  parallel words; word i = d_flat[i*WIDTH +: WIDTH]
- q  output  WIDTH  serial data word
- q_valid  output  1  q holds a word to transfer
- q_ready  input  1  downstream accepts q this cycle
- busy  output  1  high in SHIFT and DONE
- done  output  1  one-cycle pulse after the last transfer

Behaviour:
- Reset (rst_n=0 at a posedge): state=IDLE, q=0, q_valid=0, busy=0, done=0, index=0, holding registers cleared to 0. Reset overrides all other inputs.
- Reset mid-operation: next cycle is IDLE. Remaining words are dropped and no done pulse is generated.
- States: IDLE, SHIFT, DONE. All outputs are registered or decoded from registered state; there are no combinational paths from inputs to outputs.
- IDLE (busy=0, q_valid=0), on load=1:
  - latch all DEPTH words of d_flat into holding registers;
  - p_lat = p, clamped to DEPTH when p>DEPTH;
  - p_lat=0: go to DONE, no words emitted;
  - otherwise: index=p_lat-1, go to SHIFT.
- load is ignored in SHIFT and DONE. d_flat and p are don't-care outside the load cycle.
- SHIFT: q_valid=1, q=hold[index], busy=1.
  - Transfer occurs on a posedge with q_valid&&q_ready.
  - On a transfer with index==0: go to DONE. Otherwise index decrements.
  - q_ready low: q and q_valid hold unchanged. q must stay stable while q_valid=1 and no transfer has occurred.
- DONE: done=1 and busy=1 for exactly one cycle, q_valid=0, then IDLE.
  - A load asserted during the DONE cycle is ignored.
  - The earliest accepted reload is the cycle after done.
- q outside SHIFT holds its last value and has no meaning while q_valid=0.
- Latency with q_ready tied high and load at cycle 0:
  - first word valid in cycle 1;
  - p words on cycles 1..p;
  - done in cycle p+1;
  - IDLE again in cycle p+2.
- Total words transferred per load = p_lat exactly, including when stalls occur.
- Index arithmetic is CW bits wide; it never wraps below 0 because SHIFT exits on index==0.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then 1 with no load -> q_valid=0, busy=0, done=0, q=0 throughout.
- Basic burst: word i = 16'h0100+i, p=4, q_ready=1, load at cycle 0 -> q = 0103, 0102, 0101, 0100 in cycles 1-4; done=1 only in cycle 5; busy=0 in cycle 6.
- Backpressure: p=3, q_ready toggling 1,0,0,1,0,1 -> exactly 3 transfers in order 0102, 0101, 0100; q stable during every stall; done exactly one cycle after the third transfer.
- Boundaries:
  - p=0 -> no q_valid; done pulses in cycle 1.
  - p=24 -> 24 words from 0117 down to 0100.
  - p=31 -> clamped; identical to p=24.
- Ignored loads: load held high for the whole p=2 burst with d_flat changed mid-burst -> the original 2 words are sent; a load during the DONE cycle starts nothing; a load one cycle later starts a new burst.
- Reset mid-burst: p=8, rst_n=0 after 3 transfers -> next cycle q_valid=0, busy=0, no done; a fresh load afterwards sends all 8 words correctly.
